pop_wb_sequencer: RTL and testbench
===================================

// Module: pop_wb_sequencer
// PURPOSE
// Multi-cycle controller that owns the register-file write port during POP-style register-list loads.
// - Walks a register list in order, issues one memory read per set bit and writes each returned word back.
// - Arbitrates the single write port against the pipeline write-back stage; the pipeline always has priority.
// - Finishes with the SP update and, when the list includes PC, a branch. Sits beside the write-back stage.
// PARAMETERS
// WORD        32  data/address width
// ADDR_WIDTH  4   register-file address width
// LIST_WIDTH  9   register-list width: bits 0-7 = r0-r7, bit 8 = PC
// SP_ADDR     13  register-file address of SP
// PORTS
// clk_i               in   1           clock
// rst_n_i             in   1           asynchronous, active-low reset
// start_valid_i       in   1           POP request present
// start_ready_o       out  1           sequencer idle, can accept a request
// reg_list_i          in   LIST_WIDTH  register list, sampled on accept
// base_addr_i         in   WORD        current SP value, sampled on accept
// mem_req_valid_o     out  1           memory read request
// mem_req_ready_i     in   1           memory accepts the request
// mem_addr_o          out  WORD        read address
// mem_rsp_valid_i     in   1           read data valid
// mem_rsp_data_i      in   WORD        read data
// pipe_write_en_i     in   1           pipeline write-back wants the port (already ANDed with valid)
// pipe_dest_addr_i    in   ADDR_WIDTH  pipeline destination register
// pipe_data_i         in   WORD        pipeline write data
// reg_file_write_en_o out  1           muxed register-file write enable
// reg_dest_addr_o     out  ADDR_WIDTH  muxed destination register
// reg_data_o          out  WORD        muxed write data
// branch_from_wb_o    out  1           one-cycle PC-load pulse
// program_counter_o   out  WORD        target PC, valid while branch_from_wb_o=1
// stall_o             out  1           freezes the front end; 1 whenever state != IDLE
// done_o              out  1           one-cycle completion pulse
// BEHAVIOUR
// - Reset: state=IDLE; remaining list, address and pending buffer cleared.
//   All _o outputs 0 except start_ready_o=1. Reset mid-operation abandons the sequence.
//   Any later mem_rsp_valid_i arriving while IDLE is ignored.
// - States: IDLE -> ISSUE -> WAIT -> (HOLD) -> ISSUE ... -> FINAL -> IDLE.
// - IDLE: start_ready_o=1. On start_valid_i:
//   latch list, addr=base_addr_i, new_sp = base_addr_i + 4*popcount(list) (mod 2^WORD).
//   Go to ISSUE if the list is nonzero, else FINAL.
// - ISSUE: mem_req_valid_o=1, mem_addr_o=addr. Hold address stable until mem_req_ready_i.
//   On accept: addr += 4, go to WAIT.
// - WAIT: on mem_rsp_valid_i, target = lowest set bit.
//   - Bit 8 (PC): the word is stored in pc_buf and is never written to the register file.
//   - Otherwise, if pipe_write_en_i=0: write target <- data the same cycle.
//   - Otherwise: store it in the one-entry pending buffer and go to HOLD.
//   - In all cases clear the bit; go to ISSUE if bits remain, else FINAL.
// - HOLD: write the pending entry in the first cycle with pipe_write_en_i=0, then continue as WAIT would.
//   Pending is never overwritten; only one memory read is outstanding at a time.
// - FINAL: if pipe_write_en_i=0, assert done_o and return to IDLE the same cycle.
//   - Nonempty list: also write SP_ADDR <- new_sp.
//   - PC bit was set: also pulse branch_from_wb_o with program_counter_o=pc_buf.
//   - Otherwise wait in FINAL.
//   - Empty list: no writes, no branch; done_o is asserted in the cycle after accept.
// - Port mux: pipe_write_en_i=1 passes the pipe_* signals through unchanged in any state.
// - Order: ascending register number at ascending addresses; PC is always last.
// - Latency: accept at cycle T -> mem_req_valid_o at T+1. Zero memory wait and no port conflict:
//   N registers -> done_o at T+1+2N (empty list: T+1).
// - start_valid_i while not IDLE is ignored (start_ready_o=0).
// STRUCTURE
// - Shared package (GENERAL_DEFS.svh):
//   - seq_state_t enum {IDLE, ISSUE, WAIT, HOLD, FINAL}
//   - SP_ADDR and PC_LIST_BIT constants
//   - reuse reg_file_write_sig and branch_from_wb types on the muxed outputs
// - Sub-module: lowest_set_bit, a parameterised priority encoder (LIST_WIDTH -> index + any_set).
// TESTING
// 1. list=0x007, base=0x100, zero-wait memory -> reads 0x100/104/108; r0,r1,r2 written in order.
//    Then SP=0x10C and done_o at T+7; no branch.
// 2. list=0x101, base=0x200, data 0xAA then 0x300 -> r0=0xAA.
//    Then SP=0x208 + branch_from_wb_o with program_counter_o=0x300 in the same cycle as done_o.
// 3. Response arrives while pipe_write_en_i=1 for 3 cycles -> pipeline writes pass through unchanged.
//    The popped value is written in the 4th cycle; no request issued meanwhile.
// 4. mem_req_ready_i held low for 5 cycles -> mem_addr_o stable, stall_o=1 throughout, no write.
// 5. Empty list accepted -> done_o next cycle, no writes, no mem request, SP unchanged.
// 6. rst_n_i low during WAIT, then a late mem_rsp_valid_i -> all outputs reset immediately.
//    The late response is ignored and the next start runs normally.

Source files
------------

// File: rtl/pop_wb_sequencer_pkg.sv
// Shared types and constants for the POP write-back sequencer.
package pop_wb_sequencer_pkg;

  localparam int SEQ_WORD    = 32;
  localparam int SEQ_AW      = 4;
  localparam int SEQ_LW      = 9;
  localparam int SEQ_IW      = $clog2(SEQ_LW);
  localparam int SP_ADDR     = 13;
  localparam int PC_LIST_BIT = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FINAL} seq_state_t;

  typedef struct packed {
    logic                we;
    logic [SEQ_AW-1:0]   addr;
    logic [SEQ_WORD-1:0] data;
  } reg_file_write_sig;

  typedef struct packed {
    logic                valid;
    logic [SEQ_WORD-1:0] pc;
  } branch_from_wb;

  // Bytes covered by a register list: 4 per set bit.
  function automatic logic [SEQ_WORD-1:0] list_bytes(input logic [SEQ_LW-1:0] l);
    logic [SEQ_WORD-1:0] n;
    n = '0;
    for (int i = 0; i < SEQ_LW; i++) n = n + SEQ_WORD'(l[i]);
    return n << 2;
  endfunction

endpackage

// File: rtl/pop_wb_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_bit #(
  parameter int W = 9,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = W - 1; i >= 0; i--)
      if (i_vec[i]) o_idx = IW'(i);
  end

endmodule

// File: rtl/pop_wb_sequencer.sv
// POP register-list sequencer: reads each listed word, writes it back through the
// shared register-file port (pipeline has priority), then updates SP and branches.
module pop_wb_sequencer
  import pop_wb_sequencer_pkg::*;
#(
  parameter int WORD       = pop_wb_sequencer_pkg::SEQ_WORD,
  parameter int ADDR_WIDTH = pop_wb_sequencer_pkg::SEQ_AW,
  parameter int LIST_WIDTH = pop_wb_sequencer_pkg::SEQ_LW
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [LIST_WIDTH-1:0] reg_list_i,
  input  logic [WORD-1:0]       base_addr_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [WORD-1:0]       mem_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [WORD-1:0]       mem_rsp_data_i,
  input  logic                  pipe_write_en_i,
  input  logic [ADDR_WIDTH-1:0] pipe_dest_addr_i,
  input  logic [WORD-1:0]       pipe_data_i,
  output logic                  reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o,
  output logic                  branch_from_wb_o,
  output logic [WORD-1:0]       program_counter_o,
  output logic                  stall_o,
  output logic                  done_o
);

  seq_state_t            r_state, w_next;
  logic [LIST_WIDTH-1:0] r_list;
  logic [WORD-1:0]       r_addr, r_new_sp, r_pc_buf, r_pend_data;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic                  r_pc_set, r_nonempty;

  logic [SEQ_IW-1:0]     w_idx;
  logic                  w_any;
  logic                  w_is_pc;
  logic [LIST_WIDTH-1:0] w_list_cleared;
  logic                  w_more;
  reg_file_write_sig     w_seq_wr;
  branch_from_wb         w_br;

  lowest_set_bit #(.W(LIST_WIDTH), .IW(SEQ_IW)) u_lsb (
    .i_vec (r_list),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_is_pc        = w_any && (w_idx == SEQ_IW'(PC_LIST_BIT));
  assign w_list_cleared = r_list & ~(LIST_WIDTH'(1) << w_idx);
  assign w_more         = |w_list_cleared;

  // Next-state and sequencer-side write/branch/handshake decode.
  always_comb begin
    w_next          = r_state;
    start_ready_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    done_o          = 1'b0;
    w_seq_wr        = '0;
    w_br            = '0;
    case (r_state)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) w_next = (|reg_list_i) ? ISSUE : FINAL;
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          if (!w_is_pc && !pipe_write_en_i) begin
            w_seq_wr.we   = 1'b1;
            w_seq_wr.addr = SEQ_AW'(w_idx);
            w_seq_wr.data = mem_rsp_data_i;
          end
          if (!w_is_pc && pipe_write_en_i) w_next = HOLD;
          else                             w_next = w_more ? ISSUE : FINAL;
        end
      end
      HOLD: begin
        // List bit was already cleared when the word was parked.
        if (!pipe_write_en_i) begin
          w_seq_wr.we   = 1'b1;
          w_seq_wr.addr = r_pend_addr;
          w_seq_wr.data = r_pend_data;
          w_next        = (|r_list) ? ISSUE : FINAL;
        end
      end
      FINAL: begin
        if (!pipe_write_en_i) begin
          done_o = 1'b1;
          w_next = IDLE;
          if (r_nonempty) begin
            w_seq_wr.we   = 1'b1;
            w_seq_wr.addr = SEQ_AW'(SP_ADDR);
            w_seq_wr.data = r_new_sp;
          end
          if (r_pc_set) begin
            w_br.valid = 1'b1;
            w_br.pc    = r_pc_buf;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register plus list/address/buffer bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_list      <= '0;
      r_addr      <= '0;
      r_new_sp    <= '0;
      r_pc_buf    <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pc_set    <= 1'b0;
      r_nonempty  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start_valid_i) begin
          r_list     <= reg_list_i;
          r_addr     <= base_addr_i;
          r_new_sp   <= base_addr_i + list_bytes(reg_list_i);
          r_pc_set   <= reg_list_i[PC_LIST_BIT];
          r_nonempty <= |reg_list_i;
        end
        ISSUE: if (mem_req_ready_i) r_addr <= r_addr + WORD'(4);
        WAIT: if (mem_rsp_valid_i) begin
          r_list <= w_list_cleared;
          if (w_is_pc) r_pc_buf <= mem_rsp_data_i;
          else if (pipe_write_en_i) begin
            r_pend_addr <= SEQ_AW'(w_idx);
            r_pend_data <= mem_rsp_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline write-back always owns the port when it asks for it.
  assign reg_file_write_en_o = pipe_write_en_i | w_seq_wr.we;
  assign reg_dest_addr_o     = pipe_write_en_i ? pipe_dest_addr_i : w_seq_wr.addr;
  assign reg_data_o          = pipe_write_en_i ? pipe_data_i      : w_seq_wr.data;
  assign branch_from_wb_o    = w_br.valid;
  assign program_counter_o   = w_br.pc;
  assign mem_addr_o          = r_addr;
  assign stall_o             = (r_state != IDLE);

endmodule

// File: tb/tb_pop_wb_sequencer.sv
// Directed bench with a transaction-level model of expected reads/writes/branch.
module tb_pop_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready;
  logic [8:0]  reg_list;
  logic [31:0] base_addr;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        pipe_we;
  logic [3:0]  pipe_dest;
  logic [31:0] pipe_data;
  logic        reg_we;
  logic [3:0]  reg_dest;
  logic [31:0] reg_data;
  logic        branch;
  logic [31:0] pc;
  logic        stall, done;

  pop_wb_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .reg_list_i(reg_list), .base_addr_i(base_addr),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .pipe_write_en_i(pipe_we), .pipe_dest_addr_i(pipe_dest), .pipe_data_i(pipe_data),
    .reg_file_write_en_o(reg_we), .reg_dest_addr_o(reg_dest), .reg_data_o(reg_data),
    .branch_from_wb_o(branch), .program_counter_o(pc),
    .stall_o(stall), .done_o(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model state
  logic [31:0] exp_addr_q[$];
  logic [35:0] exp_wr_q[$];
  logic        exp_branch;
  logic [31:0] exp_pc;
  logic [31:0] last_sp, last_pc;
  int          got_done, done_cyc;
  logic [31:0] mem [logic [31:0]];
  logic        mem_mute, rsp_inject;
  logic [31:0] inject_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  function automatic logic [31:0] mval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'd3 + 32'h1000;
  endfunction

  // Expected traffic for one POP: reads at ascending addresses, register writes
  // in list order, then SP; PC word becomes the branch target.
  task automatic plan(input logic [8:0] list, input logic [31:0] base);
    int k;
    logic [31:0] a;
    logic [3:0]  b4;
    exp_addr_q.delete();
    exp_wr_q.delete();
    exp_branch = 1'b0;
    exp_pc     = '0;
    got_done   = 0;
    k = 0;
    for (int b = 0; b < 9; b++) begin
      if (list[b]) begin
        a = base + 32'(4 * k);
        exp_addr_q.push_back(a);
        if (b == 8) begin
          exp_branch = 1'b1;
          exp_pc     = mval(a);
        end else begin
          b4 = 4'(b);
          exp_wr_q.push_back({b4, mval(a)});
        end
        k++;
      end
    end
    if (k != 0) exp_wr_q.push_back({4'd13, base + 32'(4 * k)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [8:0] list, input logic [31:0] base, output int t);
    start_valid = 1'b1;
    reg_list    = list;
    base_addr   = base;
    t           = cyc;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t, input int lat);
    int i;
    i = 0;
    while (!got_done && i < 100) begin
      step();
      i++;
    end
    chk(name, got_done ? (done_cyc - t) : -1, lat);
  endtask

  task automatic chk_left(input string name);
    chk({name, "_wr_left"}, exp_wr_q.size(), 0);
    chk({name, "_rd_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ready"}, start_ready, 1);
    chk({name, "_ctl"}, {mem_req_valid, reg_we, branch, stall, done}, 5'b0);
    chk({name, "_addr"}, mem_addr, 0);
    chk({name, "_wr"}, {reg_dest, reg_data}, 0);
    chk({name, "_pc"}, pc, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Zero-wait memory: answers in the cycle after a request handshake.
  initial begin
    logic        hs;
    logic [31:0] ha;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && mem_req_valid && mem_req_ready && !mem_mute;
      ha = mem_addr;
      @(posedge clk);
      #2;
      mem_rsp_valid = hs | rsp_inject;
      mem_rsp_data  = rsp_inject ? inject_data : (hs ? mval(ha) : 32'h0);
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic [35:0] w;
    logic [31:0] ea;
    @(negedge clk);
    if (rst_n) begin
      chk("stall_vs_ready", stall, !start_ready);
      if (pipe_we) begin
        chk("pass_en", reg_we, 1);
        chk("pass_addr", reg_dest, pipe_dest);
        chk("pass_data", reg_data, pipe_data);
      end else if (reg_we) begin
        if (exp_wr_q.size() == 0) fail("unexpected_write", {reg_dest, reg_data});
        else begin
          w = exp_wr_q.pop_front();
          chk("wr_addr", reg_dest, w[35:32]);
          chk("wr_data", reg_data, w[31:0]);
          if (reg_dest == 4'd13) last_sp = reg_data;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0) fail("unexpected_read", mem_addr);
        else begin
          ea = exp_addr_q.pop_front();
          chk("rd_addr", mem_addr, ea);
        end
      end
      if (branch) begin
        if (!done) fail("branch_without_done", pc);
        last_pc = pc;
        chk("branch_pc", pc, exp_pc);
      end
      if (done) begin
        chk("branch_at_done", branch, exp_branch);
        got_done = 1;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst_n = 1'b0; start_valid = 1'b0; reg_list = '0; base_addr = '0;
    mem_req_ready = 1'b1; pipe_we = 1'b0; pipe_dest = '0; pipe_data = '0;
    mem_mute = 1'b0; rsp_inject = 1'b0; inject_data = '0;
    last_sp = '0; last_pc = '0; got_done = 0; done_cyc = 0; exp_branch = 1'b0; exp_pc = '0;
    step(); step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();

    // 1: three registers, zero wait
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33;
    plan(9'h007, 32'h100);
    start_seq(9'h007, 32'h100, t);
    wait_done("t1_done_lat", t, 7);
    chk("t1_sp", last_sp, 32'h10C);
    chk_left("t1");
    step();

    // 2: r0 plus PC
    mem[32'h200] = 32'hAA; mem[32'h204] = 32'h300;
    last_pc = '0;
    plan(9'h101, 32'h200);
    start_seq(9'h101, 32'h200, t);
    wait_done("t2_done_lat", t, 5);
    chk("t2_sp", last_sp, 32'h208);
    chk("t2_pc", last_pc, 32'h300);
    chk_left("t2");
    step();

    // 3: response collides with 3 cycles of pipeline writes; one more in FINAL
    mem[32'h300] = 32'h1234;
    plan(9'h003, 32'h300);
    start_seq(9'h003, 32'h300, t);
    step();
    for (int j = 0; j < 3; j++) begin
      pipe_we = 1'b1; pipe_dest = 4'(5 + j); pipe_data = 32'hDEAD0000 + 32'(j);
      @(negedge clk);
      chk("t3_no_req", mem_req_valid, 0);
      step();
    end
    pipe_we = 1'b0;
    @(negedge clk);
    chk("t3_no_req4", mem_req_valid, 0);
    chk("t3_pop_write", {reg_we, reg_dest, reg_data}, {1'b1, 4'd0, 32'h1234});
    step();
    while (cyc < t + 8) step();
    pipe_we = 1'b1; pipe_dest = 4'd7; pipe_data = 32'hCAFE0007;
    step();
    pipe_we = 1'b0;
    wait_done("t3_done_lat", t, 9);
    chk("t3_sp", last_sp, 32'h308);
    chk_left("t3");
    step();

    // 4: memory not ready for 5 cycles; a second start is ignored meanwhile
    mem_req_ready = 1'b0;
    plan(9'h010, 32'h400);
    start_seq(9'h010, 32'h400, t);
    for (int j = 0; j < 5; j++) begin
      start_valid = 1'b1; reg_list = 9'h0FF; base_addr = 32'h999;
      @(negedge clk);
      chk("t4_addr_stable", mem_addr, 32'h400);
      chk("t4_stall", stall, 1);
      chk("t4_no_write", reg_we, 0);
      step();
    end
    start_valid = 1'b0;
    mem_req_ready = 1'b1;
    wait_done("t4_done_lat", t, 8);
    chk("t4_sp", last_sp, 32'h404);
    chk_left("t4");
    step();

    // 5: empty list
    last_sp = 32'hFFFFFFFF;
    plan(9'h000, 32'h500);
    start_seq(9'h000, 32'h500, t);
    wait_done("t5_done_lat", t, 1);
    chk("t5_sp_untouched", last_sp, 32'hFFFFFFFF);
    chk_left("t5");
    step();

    // 6: reset while waiting, then a stray response, then a normal run
    mem_mute = 1'b1;
    plan(9'h00F, 32'h600);
    start_seq(9'h00F, 32'h600, t);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6_async_reset");
    exp_addr_q.delete(); exp_wr_q.delete(); exp_branch = 1'b0;
    step();
    rst_n = 1'b1; mem_mute = 1'b0;
    step();
    rsp_inject = 1'b1; inject_data = 32'hBAD;
    @(negedge clk);
    chk("t6_late_rsp_ignored", {reg_we, start_ready, stall}, 3'b010);
    step();
    rsp_inject = 1'b0;
    step();
    plan(9'h006, 32'h700);
    start_seq(9'h006, 32'h700, t);
    wait_done("t6_done_lat", t, 5);
    chk("t6_sp", last_sp, 32'h708);
    chk_left("t6");
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
